pdm_rec_buffer: RTL
===================

# pdm_rec_buffer

Parametrised record/playback buffer for decimated PDM microphone audio, the next generation of the single-channel 8-bit capture RAM. It sits after the sinc3 decimator on the 44 MHz system clock. It stores up to DEPTH multi-channel sample words and plays back exactly the recorded length. A 3-state controller takes synchronised record/play/stop buttons, and LED progress indication is scaled to any power-of-two LED count.

## Interface
- DATA_W, 8, bits per channel sample
- DEPTH, 131072, sample words stored; power of two; AW = $clog2(DEPTH)
- CHANNELS, 1, channels per word (1..4); word width W = CHANNELS*DATA_W
- LED_N, 4, progress LEDs; power of two, ≤ DEPTH; LW = $clog2(LED_N)

Ports:
- clk  in  1  system clock (44 MHz); one clock domain
- reset_n  in  1  asynchronous, active-low reset
- strobe_in  in  1  decimator data-enable level (data_en); new sample on each rising edge
- sample_in  in  W  sample word, channel 0 in bits [DATA_W-1:0]; stable while strobe_in high
- btn_rec, btn_play, btn_stop  in  1  raw asynchronous pushbuttons
- audio_out  out  W  playback sample word
- audio_valid  out  1  one-cycle pulse per new audio_out word
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY
- rec_len  out  AW+1  number of valid words in memory (0..DEPTH)
- led  out  LED_N  progress indication

## Operation
- Tick: strobe_q registers strobe_in. The tick register loads strobe_in & ~strobe_q, giving a 1-cycle pulse.
- Buttons: each button has a 3-flop shift synchroniser. Event = sync[2:1]==2'b01.
- Event priority in one cycle: stop > rec > play. Any event in a cycle suppresses that cycle's tick action.
- IDLE:
  - rec event → RECORD; wr_addr=0; rec_len=0; led=0.
  - play event with rec_len≠0 → PLAY; rd_addr=0; led=all ones.
  - play event with rec_len==0 → ignored.
- RECORD:
  - Each tick: mem[wr_addr]<=sample_in; wr_addr++; rec_len++; led[wr_addr[AW-1 -: LW]]<=1.
  - Tick at wr_addr==DEPTH-1: write completes; rec_len=DEPTH; wr_addr=0; → IDLE.
  - stop event → IDLE; rec_len keeps the count written so far.
  - rec event → restart: wr_addr=0, rec_len=0, led=0.
  - play event ignored.
- PLAY:
  - Each tick: audio_out<=rd_data; audio_valid<=1; rd_addr++; led[~rd_addr[AW-1 -: LW]]<=0.
  - Tick consuming rd_addr==rec_len-1: → IDLE (see Configuration).
  - stop event → IDLE.
  - rec event → RECORD (same entry actions as from IDLE).
  - play event → restart at rd_addr=0.
- Memory: simple dual-port, W×DEPTH, inferred block RAM, no reset.
  - rd_data <= mem[rd_addr] every cycle (registered read, prefetch).
- audio_out is forced to 0 whenever state≠PLAY. There is no tristate.

## Timing
- Reset values: state=IDLE, audio_out=0, audio_valid=0, rec_len=0, led=0, wr_addr=rd_addr=0, all sync/strobe flops 0.
- Strobe latency: strobe_in first sampled high at edge N. Tick is high after edge N+1. Write / audio_valid take effect at edge N+2.
- Button latency: first sampled high at edge N. Event is visible after edge N+2. State changes at edge N+3.
- strobe_in period must be ≥4 clk cycles. This guarantees rd_data is refreshed after rd_addr++ before the next tick. Behaviour at shorter periods is not defined.
- audio_valid is high exactly one cycle per tick in PLAY. audio_out holds between pulses.
- rec_len updates in the same cycle as the write.
- reset_n low mid-operation: immediate return to reset values. Memory contents are kept, but rec_len=0 makes them unplayable.

## Configuration
- PDM_REC_LOOP_EN defined: at the end of the recording, rd_addr wraps to 0, all LEDs re-light, and PLAY continues until a stop or rec event.
- Not defined: end of the recording returns to IDLE with audio_out=0.

## Test plan
- Reset, then btn_rec, then 8 strobes (period 16, samples 0x10..0x17), then btn_stop → rec_len=8, state=IDLE, mem[0..7]=0x10..0x17.
- btn_play after the above, then 8 strobes → audio_valid pulses 8 times with 0x10..0x17, then state=IDLE and audio_out=0. Loop build: the 9th strobe yields 0x10.
- DEPTH=16, LED_N=4, record 16 ticks → led lights one bit per 4 samples (0001, 0011, 0111, 1111), rec_len=16, auto IDLE.
- btn_play with rec_len=0 → state stays IDLE, no audio_valid.
- btn_stop and strobe rising edge in the same cycle during RECORD → no write, rec_len unchanged, state=IDLE.
- CHANNELS=2: record 0xAB_CD, then play back → audio_out=16'hABCD. Assert reset_n mid-PLAY → all outputs return to reset values within 1 cycle.

Source files
------------

// File: rtl/pdm_rec_buffer.sv
// Record/playback buffer for decimated multi-channel PDM audio with a 3-state
// controller and LED progress bar. Define PDM_REC_LOOP_EN for looping playback.
module pdm_rec_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 131072,
  parameter int CHANNELS = 1,
  parameter int LED_N    = 4,
  localparam int W  = CHANNELS * DATA_W,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(LED_N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          strobe_in,
  input  logic [W-1:0]  sample_in,
  input  logic          btn_rec,
  input  logic          btn_play,
  input  logic          btn_stop,
  output logic [W-1:0]  audio_out,
  output logic          audio_valid,
  output logic [1:0]    state,
  output logic [AW:0]   rec_len,
  output logic [LED_N-1:0] led
);

`ifdef PDM_REC_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int LWI = (LW > 0) ? LW : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_PLAY   = 2'b10
  } state_t;

  state_t st_q, st_d;

  logic          strobe_q, tick;
  logic [2:0]    rec_sync, play_sync, stop_sync;
  logic          ev_rec, ev_play, ev_stop, do_tick;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  rd_data;
  logic          start_rec, start_play, wr_en, rd_step, rd_wrap, last_rd;

  logic [W-1:0]  mem [DEPTH];

  // Upper address bits select the LED; playback clears from the top down.
  function automatic logic [LWI-1:0] led_idx(input logic [AW-1:0] a);
    if (LW == 0) return '0;
    return LWI'(a >> (AW - LW));
  endfunction

  function automatic logic [LWI-1:0] play_idx(input logic [AW-1:0] a);
    if (LW == 0) return '0;
    return ~led_idx(a);
  endfunction

  assign state   = st_q;
  assign ev_rec  = (rec_sync[2:1]  == 2'b01);
  assign ev_play = (play_sync[2:1] == 2'b01);
  assign ev_stop = (stop_sync[2:1] == 2'b01);
  assign do_tick = tick & ~(ev_rec | ev_play | ev_stop);
  assign last_rd = ({1'b0, rd_addr} == rec_len - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= S_IDLE;
      strobe_q  <= 1'b0;
      tick      <= 1'b0;
      rec_sync  <= '0;
      play_sync <= '0;
      stop_sync <= '0;
    end else begin
      st_q      <= st_d;
      strobe_q  <= strobe_in;
      tick      <= strobe_in & ~strobe_q;
      rec_sync  <= {rec_sync[1:0],  btn_rec};
      play_sync <= {play_sync[1:0], btn_play};
      stop_sync <= {stop_sync[1:0], btn_stop};
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    st_d       = st_q;
    start_rec  = 1'b0;
    start_play = 1'b0;
    wr_en      = 1'b0;
    rd_step    = 1'b0;
    rd_wrap    = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (!ev_stop) begin
          if (ev_rec) begin
            st_d      = S_RECORD;
            start_rec = 1'b1;
          end else if (ev_play && rec_len != '0) begin
            st_d       = S_PLAY;
            start_play = 1'b1;
          end
        end
      end
      S_RECORD: begin
        if (ev_stop) begin
          st_d = S_IDLE;
        end else if (ev_rec) begin
          start_rec = 1'b1;
        end else if (do_tick) begin
          wr_en = 1'b1;
          if (wr_addr == AW'(DEPTH - 1)) st_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (ev_stop) begin
          st_d = S_IDLE;
        end else if (ev_rec) begin
          st_d      = S_RECORD;
          start_rec = 1'b1;
        end else if (ev_play) begin
          start_play = 1'b1;
        end else if (do_tick) begin
          rd_step = 1'b1;
          if (last_rd) begin
            if (LOOP_EN) rd_wrap = 1'b1;
            else         st_d    = S_IDLE;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // audio_out clears one cycle after leaving PLAY so the final word is still seen with its pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      rec_len     <= '0;
      led         <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      if (st_q != S_PLAY) audio_out <= '0;
      if (start_rec) begin
        wr_addr <= '0;
        rec_len <= '0;
        led     <= '0;
      end
      if (wr_en) begin
        wr_addr               <= wr_addr + 1'b1;
        rec_len               <= rec_len + 1'b1;
        led[led_idx(wr_addr)] <= 1'b1;
      end
      if (start_play) begin
        rd_addr <= '0;
        led     <= '1;
      end
      if (rd_step) begin
        audio_out   <= rd_data;
        audio_valid <= 1'b1;
        if (rd_wrap) begin
          rd_addr <= '0;
          led     <= '1;
        end else begin
          rd_addr                <= rd_addr + 1'b1;
          led[play_idx(rd_addr)] <= 1'b0;
        end
      end
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; rec_len gates its validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample_in;
    rd_data <= mem[rd_addr];
  end

endmodule
